// File: rtl/renas_write_buffer.sv
// Cache-side write buffer: circular FIFO of word writes with same-address coalescing,
// a youngest-match read lookup, and a one-word-per-transfer req/ack drain to main memory.
module renas_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
) (
    input  logic                     cache_clk,
    input  logic                     rst_n,
    input  logic                     i_wr_valid,
    input  logic [ADDR_W-1:0]        i_wr_addr,
    input  logic [DATA_W-1:0]        i_wr_data,
    output logic                     o_wr_ready,
    input  logic [ADDR_W-1:0]        i_rd_addr,
    output logic                     o_rd_hit,
    output logic [DATA_W-1:0]        o_rd_data,
    output logic [DATA_W+ADDR_W-1:0] o_wb_data,
    output logic                     o_wb_req,
    input  logic                     i_wb_ack,
    input  logic                     i_full_flag,
    output logic                     o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_HOLD} state_t;

    logic [DEPTH-1:0]            r_valid;
    logic [ADDR_W-1:0]           r_addr [DEPTH];
    logic [DATA_W-1:0]           r_data [DEPTH];
    logic [PTR_W-1:0]            r_wr_ptr;
    logic [PTR_W-1:0]            r_rd_ptr;
    logic [CNT_W-1:0]            r_count;
    state_t                      r_state;
    logic                        r_wb_req;
    logic [DATA_W+ADDR_W-1:0]    r_wb_data;

    logic                        w_empty;
    logic                        w_start;
    logic                        w_lock;
    logic                        w_pop;
    logic                        w_fire;
    logic                        w_alloc;
    logic                        w_coal;
    logic [PTR_W-1:0]            w_coal_idx;
    logic [DEPTH-1:0]            w_match;
    logic [PTR_W-1:0]            w_lk_idx;

    assign w_empty    = (r_count == '0);
    assign o_wr_ready = (r_count != CNT_W'(DEPTH));
    assign w_start    = (r_state == ST_IDLE) && !w_empty && !i_full_flag && !i_wb_ack;
    // The head is locked in the same cycle it is latched, so a coalesce never lands on data already sent.
    assign w_lock     = (r_state == ST_REQ) || w_start;
    assign w_pop      = (r_state == ST_REQ) && i_wb_ack;
    assign w_fire     = i_wr_valid && o_wr_ready;
    assign w_coal     = w_fire && (|w_match);
    assign w_alloc    = w_fire && !(|w_match);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            assign w_match[gi] = r_valid[gi] && (r_addr[gi] == i_wr_addr) &&
                                 !(w_lock && (r_rd_ptr == PTR_W'(gi)));
        end
    endgenerate

    always_comb begin
        w_coal_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_match[i]) w_coal_idx = PTR_W'(i);
        end
    end

    // Valid entries are contiguous from rd_ptr, so walking forward ends on the youngest match.
    always_comb begin
        o_rd_hit  = 1'b0;
        o_rd_data = '0;
        w_lk_idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_lk_idx = r_rd_ptr + PTR_W'(k);
            if (r_valid[w_lk_idx] && (r_addr[w_lk_idx] == i_rd_addr)) begin
                o_rd_hit  = 1'b1;
                o_rd_data = r_data[w_lk_idx];
            end
        end
    end

    always_ff @(posedge cache_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_alloc && (r_wr_ptr == PTR_W'(i))) begin
                    r_valid[i] <= 1'b1;
                    r_addr[i]  <= i_wr_addr;
                    r_data[i]  <= i_wr_data;
                end
                if (w_coal && (w_coal_idx == PTR_W'(i))) r_data[i] <= i_wr_data;
                if (w_pop && (r_rd_ptr == PTR_W'(i))) r_valid[i] <= 1'b0;
            end
            if (w_alloc) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CNT_W'(w_alloc) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge cache_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_wb_req  <= 1'b0;
            r_wb_data <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_start) begin
                    r_state   <= ST_REQ;
                    r_wb_req  <= 1'b1;
                    r_wb_data <= {r_data[r_rd_ptr], r_addr[r_rd_ptr]};
                end
                ST_REQ: if (i_wb_ack) begin
                    r_state  <= ST_HOLD;
                    r_wb_req <= 1'b0;
                end
                ST_HOLD: if (!i_wb_ack) r_state <= ST_IDLE;
                default: begin
                    r_state  <= ST_IDLE;
                    r_wb_req <= 1'b0;
                end
            endcase
        end
    end

    assign o_wb_req  = r_wb_req;
    assign o_wb_data = r_wb_data;
    assign o_empty   = w_empty;
    assign o_count   = r_count;
endmodule

// File: tb/tb_renas_write_buffer.sv
// Bench for renas_write_buffer: directed pushes feed an expected-transfer queue that a
// negedge monitor checks against every new memory request, also acting as the memory acker.
module tb_renas_write_buffer;
    logic        cache_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic [29:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        wr_ready;
    logic [29:0] rd_addr = '0;
    logic        rd_hit;
    logic [31:0] rd_data;
    logic [61:0] wb_data;
    logic        wb_req;
    logic        wb_ack = 1'b0;
    logic        full_flag = 1'b0;
    logic        empty;
    logic [2:0]  count;

    int checks = 0;
    int failures = 0;
    logic [61:0] exp_q[$];
    bit auto_ack = 1'b1;
    bit prev_req = 1'b0;

    always #5 cache_clk = ~cache_clk;

    renas_write_buffer #(.DEPTH(4), .ADDR_W(30), .DATA_W(32)) dut (
        .cache_clk(cache_clk), .rst_n(rst_n),
        .i_wr_valid(wr_valid), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_ready(wr_ready),
        .i_rd_addr(rd_addr), .o_rd_hit(rd_hit), .o_rd_data(rd_data),
        .o_wb_data(wb_data), .o_wb_req(wb_req), .i_wb_ack(wb_ack),
        .i_full_flag(full_flag), .o_empty(empty), .o_count(count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Monitor: compare each new request against the scoreboard, and ack when enabled.
    initial begin
        forever begin
            @(negedge cache_clk);
            if (rst_n && wb_req && !prev_req) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_transfer: got %h expected none", wb_data);
                end else begin
                    check("transfer", {2'b00, wb_data}, {2'b00, exp_q.pop_front()});
                end
            end
            prev_req = wb_req;
            wb_ack = auto_ack && wb_req && rst_n;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic push(input logic [29:0] a, input logic [31:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        @(posedge cache_clk);
        #1;
        wr_valid = 1'b0;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge cache_clk);
            #1;
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((!empty || wb_req) && n < 200) begin
            tick(1);
            n++;
        end
        tick(3);
        check(name, {63'd0, empty}, 64'd1);
    endtask

    initial begin
        // Reset state
        #12;
        check("reset_count", {61'd0, count}, 64'd0);
        check("reset_empty", {63'd0, empty}, 64'd1);
        check("reset_wb_req", {63'd0, wb_req}, 64'd0);
        check("reset_wb_data", {2'b00, wb_data}, 64'd0);
        @(negedge cache_clk);
        rst_n = 1'b1;
        tick(1);
        check("reset_wr_ready", {63'd0, wr_ready}, 64'd1);

        // 1: single push, latency and single-cycle ack
        exp_q.push_back({32'hDEADBEEF, 30'h100});
        push(30'h100, 32'hDEADBEEF);
        check("t1_req_low_after_push", {63'd0, wb_req}, 64'd0);
        tick(1);
        check("t1_req_high_2nd_edge", {63'd0, wb_req}, 64'd1);
        tick(1);
        check("t1_count_after_ack", {61'd0, count}, 64'd0);
        check("t1_empty_after_ack", {63'd0, empty}, 64'd1);
        check("t1_req_low_after_ack", {63'd0, wb_req}, 64'd0);
        tick(2);

        // 2: fill with memory busy, overflow push dropped, FIFO drain order
        full_flag = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back({32'hA0 + 32'(i), 30'(i)});
            push(30'(i), 32'hA0 + 32'(i));
        end
        check("t2_count_full", {61'd0, count}, 64'd4);
        check("t2_wr_ready_low", {63'd0, wr_ready}, 64'd0);
        push(30'h5, 32'hA5);
        check("t2_fifth_dropped", {61'd0, count}, 64'd4);
        check("t2_no_req_busy", {63'd0, wb_req}, 64'd0);
        full_flag = 1'b0;
        drain("t2_drained");

        // 3: coalescing of a non-locked entry
        full_flag = 1'b1;
        exp_q.push_back({32'hB, 30'h10});
        push(30'h10, 32'hA);
        push(30'h10, 32'hB);
        check("t3_coalesced_count", {61'd0, count}, 64'd1);
        full_flag = 1'b0;
        drain("t3_drained");

        // 4: push to the locked head address allocates a second entry
        auto_ack = 1'b0;
        exp_q.push_back({32'h1, 30'h20});
        exp_q.push_back({32'h2, 30'h20});
        push(30'h20, 32'h1);
        tick(1);
        check("t4_head_in_req", {63'd0, wb_req}, 64'd1);
        push(30'h20, 32'h2);
        check("t4_locked_alloc_count", {61'd0, count}, 64'd2);
        auto_ack = 1'b1;
        drain("t4_drained");

        // 5: read lookup
        full_flag = 1'b1;
        exp_q.push_back({32'h55, 30'h30});
        exp_q.push_back({32'h66, 30'h31});
        push(30'h30, 32'h55);
        push(30'h31, 32'h66);
        rd_addr = 30'h30;
        #1;
        check("t5_hit_30", {63'd0, rd_hit}, 64'd1);
        check("t5_data_30", {32'd0, rd_data}, 64'h55);
        rd_addr = 30'h31;
        #1;
        check("t5_data_31", {32'd0, rd_data}, 64'h66);
        rd_addr = 30'h40;
        #1;
        check("t5_hit_40", {63'd0, rd_hit}, 64'd0);
        check("t5_data_40", {32'd0, rd_data}, 64'd0);
        full_flag = 1'b0;
        drain("t5_drained");

        // 6: asynchronous reset while a transfer is pending
        full_flag = 1'b1;
        auto_ack = 1'b0;
        exp_q.push_back({32'h500, 30'h50});
        push(30'h50, 32'h500);
        push(30'h51, 32'h510);
        push(30'h52, 32'h520);
        full_flag = 1'b0;
        tick(1);
        check("t6_in_req", {63'd0, wb_req}, 64'd1);
        check("t6_count3", {61'd0, count}, 64'd3);
        @(negedge cache_clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_req_dropped_async", {63'd0, wb_req}, 64'd0);
        check("t6_count_cleared", {61'd0, count}, 64'd0);
        check("t6_empty", {63'd0, empty}, 64'd1);
        tick(2);
        @(negedge cache_clk);
        rst_n = 1'b1;
        auto_ack = 1'b1;
        tick(4);
        check("t6_idle_after_reset", {63'd0, wb_req}, 64'd0);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
